// File: rtl/adc_dly_cal_ctrl.sv
// adc_dly_cal_ctrl: IODELAY tap-sweep calibration sequencer for a 4-channel ADC receive interface.
// Optional feature macro ADC_CAL_OR_CHECK_EN: when defined, data_or[ch] during CHECK counts as a compare error.
module adc_dly_cal_ctrl #(
    parameter int         TAP_W       = 9,
    parameter int         RST_CYC     = 32,
    parameter int         SETTLE_CYC  = 16,
    parameter int         CMP_CYC     = 64,
    parameter logic [9:0] PATTERN     = 10'h2AA,
    parameter int         MIN_WIN     = 8,
    parameter int         TAP_DEFAULT = 0
) (
    input  logic                 clk_div,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [159:0]         data_in,
    input  logic [3:0]           data_or,
    output logic                 rst_iodelay,
    output logic                 rst_serdes,
    output logic [3:0]           load,
    output logic [4*TAP_W-1:0]   cntvalue,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           fail
);
    localparam int LEN_W = TAP_W + 1;
    localparam logic [TAP_W-1:0] TAP_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_RST_DLY, S_RST_SER, S_SET, S_SETTLE, S_CHECK, S_EVAL, S_FINAL, S_DONE
    } state_t;

    state_t             r_state, w_next;
    logic [15:0]        r_cyc;
    logic [1:0]         r_ch;
    logic [TAP_W-1:0]   r_tap;
    logic               r_err;
    logic [159:0]       r_data;
    logic [TAP_W-1:0]   r_cur_start, r_best_start;
    logic [LEN_W-1:0]   r_cur_len, r_best_len;
    logic               r_rst_iod, r_rst_ser, r_busy, r_done;
    logic [3:0]         r_load, r_fail;
    logic [4*TAP_W-1:0] r_cntv;
    logic [39:0]        w_word;
    logic               w_mis, w_bad, w_pass, w_close, w_win_ok;
    logic [LEN_W-1:0]   w_len_upd;
    logic [TAP_W-1:0]   w_start_upd, w_center;

    assign rst_iodelay = r_rst_iod;
    assign rst_serdes  = r_rst_ser;
    assign load        = r_load;
    assign cntvalue    = r_cntv;
    assign busy        = r_busy;
    assign done        = r_done;
    assign fail        = r_fail;

    // Compare the registered samples of the active channel against the test pattern
    always_comb begin
        w_word = r_data[40*r_ch +: 40];
        w_mis  = 1'b0;
        for (int i = 0; i < 4; i++)
            if (w_word[10*i +: 10] != PATTERN) w_mis = 1'b1;
    end

`ifdef ADC_CAL_OR_CHECK_EN
    logic [3:0] r_or;
    // Out-of-range flags share the same one-cycle register delay as the samples
    always_ff @(posedge clk_div or negedge rst_n)
        if (!rst_n) r_or <= '0;
        else        r_or <= data_or;
    assign w_bad = w_mis | r_or[r_ch];
`else
    logic w_unused_or;
    assign w_unused_or = ^data_or;
    assign w_bad = w_mis;
`endif

    // Window bookkeeping for the tap just measured, and centre of the best window
    always_comb begin
        w_pass      = !r_err;
        w_len_upd   = r_cur_len + LEN_W'(w_pass);
        w_start_upd = (w_pass && r_cur_len == '0) ? r_tap : r_cur_start;
        w_close     = !w_pass || r_tap == TAP_MAX;
        w_win_ok    = r_best_len >= LEN_W'(MIN_WIN);
        w_center    = r_best_start + r_best_len[TAP_W:1];
    end

    // Next-state logic for the calibration sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_RST_DLY;
            S_RST_DLY:      if (r_cyc == 16'(RST_CYC - 1)) w_next = S_RST_SER;
            S_RST_SER:      if (r_cyc == 16'(RST_CYC - 1)) w_next = S_SET;
            S_SET:          w_next = S_SETTLE;
            S_SETTLE:       if (r_cyc == 16'(SETTLE_CYC - 1)) w_next = S_CHECK;
            S_CHECK:        if (r_cyc == 16'(CMP_CYC - 1)) w_next = S_EVAL;
            S_EVAL:         w_next = (r_tap == TAP_MAX) ? S_FINAL : S_SET;
            S_FINAL:        w_next = (r_ch == 2'd3) ? S_DONE : S_SET;
            default:        w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_div or negedge rst_n)
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;

    // Sequencer datapath: phase counter, sweep position, window tracking and registered outputs
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc        <= '0;
            r_ch         <= '0;
            r_tap        <= '0;
            r_err        <= 1'b0;
            r_data       <= '0;
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
            r_rst_iod    <= 1'b1;
            r_rst_ser    <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load       <= '0;
            r_fail       <= '0;
            r_cntv       <= '0;
        end else begin
            r_data <= data_in;
            r_load <= '0;
            r_cyc  <= (w_next != r_state) ? '0 : r_cyc + 16'd1;
            case (r_state)
                S_IDLE, S_DONE: if (start) begin
                    r_busy    <= 1'b1;
                    r_done    <= 1'b0;
                    r_fail    <= '0;
                    r_cntv    <= '0;
                    r_rst_iod <= 1'b1;
                    r_rst_ser <= 1'b1;
                end
                S_RST_DLY: if (w_next == S_RST_SER) r_rst_iod <= 1'b0;
                S_RST_SER: if (w_next == S_SET) begin
                    r_rst_ser <= 1'b0;
                    r_ch      <= '0;
                    r_tap     <= '0;
                end
                S_SET: begin
                    r_cntv[TAP_W*r_ch +: TAP_W] <= r_tap;
                    r_load[r_ch]                <= 1'b1;
                    r_err                       <= 1'b0;
                end
                S_CHECK: if (w_bad) r_err <= 1'b1;
                S_EVAL: begin
                    if (w_close) begin
                        if (w_len_upd > r_best_len) begin
                            r_best_start <= w_start_upd;
                            r_best_len   <= w_len_upd;
                        end
                        r_cur_len <= '0;
                    end else begin
                        r_cur_start <= w_start_upd;
                        r_cur_len   <= w_len_upd;
                    end
                    if (r_tap != TAP_MAX) r_tap <= r_tap + 1'b1;
                end
                S_FINAL: begin
                    r_cntv[TAP_W*r_ch +: TAP_W] <= w_win_ok ? w_center : TAP_W'(TAP_DEFAULT);
                    if (!w_win_ok) r_fail[r_ch] <= 1'b1;
                    r_load[r_ch] <= 1'b1;
                    r_best_start <= '0;
                    r_best_len   <= '0;
                    r_cur_start  <= '0;
                    r_cur_len    <= '0;
                    if (r_ch != 2'd3) begin
                        r_ch  <= r_ch + 2'd1;
                        r_tap <= '0;
                    end else begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_dly_cal_ctrl.sv
// tb_adc_dly_cal_ctrl: scoreboard bench driving a behavioural ADC/IODELAY model into the calibration sequencer.
module tb_adc_dly_cal_ctrl;
    localparam int TAP_W      = 9;
    localparam int RST_CYC    = 4;
    localparam int SETTLE_CYC = 3;
    localparam int CMP_CYC    = 1;
    localparam logic [9:0] PATTERN = 10'h2AA;
    localparam int RUN_BOUND  = 4 * (512 * (SETTLE_CYC + CMP_CYC + 2) + 1) + 4 * RST_CYC + 200;
`ifdef ADC_CAL_OR_CHECK_EN
    localparam int OR_EXP = 384;
`else
    localparam int OR_EXP = 256;
`endif

    typedef struct packed {
        logic [4*TAP_W-1:0] cnt;
        logic [3:0]         fail;
    } exp_t;

    logic clk_div = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [159:0] data_in;
    logic [3:0] data_or;
    logic rst_iodelay, rst_serdes, busy, done;
    logic [3:0] load, fail;
    logic [4*TAP_W-1:0] cntvalue;
    int n_vec = 0;
    int n_mis = 0;
    int mode = 0;
    int tap_m[4];
    int load_cnt[4];
    exp_t sb[$];

    always #5 clk_div = ~clk_div;

    adc_dly_cal_ctrl #(
        .TAP_W(TAP_W), .RST_CYC(RST_CYC), .SETTLE_CYC(SETTLE_CYC), .CMP_CYC(CMP_CYC),
        .PATTERN(PATTERN), .MIN_WIN(8), .TAP_DEFAULT(0)
    ) dut (
        .clk_div(clk_div), .rst_n(rst_n), .start(start), .data_in(data_in), .data_or(data_or),
        .rst_iodelay(rst_iodelay), .rst_serdes(rst_serdes), .load(load), .cntvalue(cntvalue),
        .busy(busy), .done(done), .fail(fail)
    );

    // Eye model: which taps of a channel give a clean capture in each scenario
    function automatic bit pass_f(input int m, input int c, input int t);
        if (m != 1) return 1'b1;
        case (c)
            0:       return t >= 480;
            1:       return t >= 100 && t <= 139;
            2:       return (t >= 10 && t <= 29) || (t >= 300 && t <= 319);
            default: return t <= 4;
        endcase
    endfunction

    // ADC output: a closed eye corrupts one of the four samples of that channel
    always_comb begin
        data_in = '0;
        for (int c = 0; c < 4; c++)
            for (int s = 0; s < 4; s++)
                data_in[40*c + 10*s +: 10] = (pass_f(mode, c, tap_m[c]) || s != tap_m[c] % 4) ? PATTERN : ~PATTERN;
        data_or = (mode == 3 && tap_m[0] <= 255) ? 4'b0001 : 4'b0000;
    end

    // IODELAY model: a load strobe latches the channel's tap value
    always @(negedge clk_div)
        for (int c = 0; c < 4; c++)
            if (load[c]) begin
                tap_m[c]    <= int'(cntvalue[TAP_W*c +: TAP_W]);
                load_cnt[c] <= load_cnt[c] + 1;
            end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk_div);
        chk("busy_before_start", busy, 0);
        start = 1'b1;
        @(posedge clk_div);
        #1;
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("done_clear", done, 0);
        repeat (RST_CYC - 1) begin @(posedge clk_div); #1; end
        chk("iod_held", rst_iodelay, 1);
        @(posedge clk_div);
        #1;
        chk("iod_fall", rst_iodelay, 0);
        chk("ser_held_a", rst_serdes, 1);
        repeat (RST_CYC - 1) begin @(posedge clk_div); #1; end
        chk("ser_held_b", rst_serdes, 1);
        @(posedge clk_div);
        #1;
        chk("ser_fall", rst_serdes, 0);
    endtask

    task automatic run_cal(input int m, input int e0, input int e1, input int e2, input int e3, input logic [3:0] ef);
        exp_t e;
        int base[4];
        bit seen;
        mode = m;
        e.cnt  = {TAP_W'(e3), TAP_W'(e2), TAP_W'(e1), TAP_W'(e0)};
        e.fail = ef;
        sb.push_back(e);
        base = load_cnt;
        do_start();
        seen = 1'b0;
        for (int i = 0; i < RUN_BOUND && !seen; i++) begin
            @(posedge clk_div);
            #1;
            seen = done;
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk_div);
        #1;
        e = sb.pop_front();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("m%0d_cnt%0d", m, c), cntvalue[TAP_W*c +: TAP_W], e.cnt[TAP_W*c +: TAP_W]);
            chk($sformatf("m%0d_loads%0d", m, c), load_cnt[c] - base[c], 513);
        end
        chk($sformatf("m%0d_fail", m), fail, e.fail);
        chk($sformatf("m%0d_busy_end", m), busy, 0);
        chk($sformatf("m%0d_done", m), done, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_iod"}, rst_iodelay, 1);
        chk({tag, "_ser"}, rst_serdes, 1);
        chk({tag, "_load"}, load, 0);
        chk({tag, "_cnt"}, cntvalue, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_fail"}, fail, 0);
    endtask

    initial begin
        int base2;
        bool_wait: begin end
        repeat (3) @(posedge clk_div);
        #1;
        chk_reset_vals("por");
        @(negedge clk_div);
        rst_n = 1'b1;
        run_cal(0, 256, 256, 256, 256, 4'b0000);
        run_cal(1, 496, 120, 20, 0, 4'b1000);
        mode = 1;
        base2 = load_cnt[2];
        do_start();
        for (int i = 0; i < RUN_BOUND && load_cnt[2] - base2 < 50; i++) @(posedge clk_div);
        chk("abort_reached_ch2", load_cnt[2] - base2 >= 50, 1);
        @(negedge clk_div);
        chk("abort_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        repeat (3) @(negedge clk_div);
        rst_n = 1'b1;
        run_cal(1, 496, 120, 20, 0, 4'b1000);
        run_cal(3, OR_EXP, 256, 256, 256, 4'b0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
